// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU control path.
package cpu_pkg;

    // Opcode field values (instr[31:28])
    localparam logic [3:0] OP_RTYPE  = 4'h0;
    localparam logic [3:0] OP_ITYPE  = 4'h1;
    localparam logic [3:0] OP_LOAD   = 4'h2;
    localparam logic [3:0] OP_STORE  = 4'h3;
    localparam logic [3:0] OP_BRANCH = 4'h4;
    localparam logic [3:0] OP_JUMP   = 4'h5;
    localparam logic [3:0] OP_HALT   = 4'hF;

    // ALU operation selects
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;

    // Branch condition selects
    localparam logic [1:0] BC_EQ = 2'b00;
    localparam logic [1:0] BC_NE = 2'b01;
    localparam logic [1:0] BC_LT = 2'b10;
    localparam logic [1:0] BC_LE = 2'b11;

    // PC source selects
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_HALT,
        CLS_ILLEGAL
    } iclass_e;

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction classifier: opcode class, ALU field, branch cond, illegal flag.
module cpu_instr_decode
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instr_i,
    output iclass_e               class_o,
    output logic [3:0]            alu_o,
    output logic [1:0]            cond_o,
    output logic                  illegal_o
);

    logic [3:0] opcode;
    logic       unused_low_bits;

    assign opcode          = instr_i[DATA_WIDTH-1 -: 4];
    assign alu_o           = instr_i[DATA_WIDTH-5 -: 4];
    assign cond_o          = instr_i[DATA_WIDTH-7 -: 2];
    assign unused_low_bits = ^instr_i[DATA_WIDTH-9:0];

    // Map opcode to class; RTYPE/ITYPE with ALU field 8..15 are illegal
    always_comb begin
        class_o = CLS_ILLEGAL;
        case (opcode)
            OP_RTYPE:  class_o = alu_o[3] ? CLS_ILLEGAL : CLS_RTYPE;
            OP_ITYPE:  class_o = alu_o[3] ? CLS_ILLEGAL : CLS_ITYPE;
            OP_LOAD:   class_o = CLS_LOAD;
            OP_STORE:  class_o = CLS_STORE;
            OP_BRANCH: class_o = CLS_BRANCH;
            OP_JUMP:   class_o = CLS_JUMP;
            OP_HALT:   class_o = CLS_HALT;
            default:   class_o = CLS_ILLEGAL;
        endcase
        illegal_o = (class_o == CLS_ILLEGAL);
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath strobes,
// ALU select production and retired-instruction counting.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int ALU_SELECT_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DATA_WIDTH-1:0]       instr,
    input  logic                        zero,
    input  logic                        mem_ready,
    output logic [ALU_SELECT_WIDTH-1:0] alu_op,
    output logic [1:0]                  branch_cond,
    output logic                        alu_src_b,
    output logic                        pc_write,
    output logic [1:0]                  pc_src,
    output logic                        ir_write,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic                        iord,
    output logic                        reg_write,
    output logic                        mem_to_reg,
    output logic                        halted,
    output logic                        trap,
    output logic [DATA_WIDTH-1:0]       retired
);

    state_e                state_q;
    iclass_e               class_q;
    logic [3:0]            alu_q;
    logic [1:0]            cond_q;
    logic [DATA_WIDTH-1:0] retired_q;

    iclass_e               dec_class;
    logic [3:0]            dec_alu;
    logic [1:0]            dec_cond;
    logic                  dec_illegal;

    cpu_instr_decode #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_decode (
        .instr_i   (instr),
        .class_o   (dec_class),
        .alu_o     (dec_alu),
        .cond_o    (dec_cond),
        .illegal_o (dec_illegal)
    );

    assign retired = retired_q;

    // State sequencing, DECODE-time field latch and retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            class_q   <= CLS_RTYPE;
            alu_q     <= '0;
            cond_q    <= '0;
            retired_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) state_q <= ST_DECODE;
                end
                ST_DECODE: begin
                    class_q <= dec_class;
                    alu_q   <= dec_alu;
                    cond_q  <= dec_cond;
                    if (dec_illegal)                 state_q <= ST_TRAP;
                    else if (dec_class == CLS_HALT)  state_q <= ST_HALT;
                    else                             state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (class_q)
                        CLS_RTYPE, CLS_ITYPE: state_q <= ST_WB;
                        CLS_LOAD, CLS_STORE:  state_q <= ST_MEM;
                        CLS_BRANCH, CLS_JUMP: begin
                            state_q   <= ST_FETCH;
                            retired_q <= retired_q + DATA_WIDTH'(1);
                        end
                        default:              state_q <= ST_TRAP;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready) begin
                        if (class_q == CLS_LOAD) begin
                            state_q <= ST_WB;
                        end else begin
                            state_q   <= ST_FETCH;
                            retired_q <= retired_q + DATA_WIDTH'(1);
                        end
                    end
                end
                ST_WB: begin
                    state_q   <= ST_FETCH;
                    retired_q <= retired_q + DATA_WIDTH'(1);
                end
                ST_HALT: state_q <= ST_HALT;
                ST_TRAP: state_q <= ST_TRAP;
                default: state_q <= ST_FETCH;
            endcase
        end
    end

    // Output decode from registered state and latched class; the FETCH handshake
    // and the branch-taken strobe follow mem_ready/zero within the same cycle
    always_comb begin
        alu_op      = '0;
        branch_cond = BC_EQ;
        alu_src_b   = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_SEQ;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        halted      = 1'b0;
        trap        = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_EXEC: begin
                    case (class_q)
                        CLS_RTYPE: alu_op = ALU_SELECT_WIDTH'(alu_q);
                        CLS_ITYPE: begin
                            alu_op    = ALU_SELECT_WIDTH'(alu_q);
                            alu_src_b = 1'b1;
                        end
                        CLS_LOAD, CLS_STORE: begin
                            alu_op    = ALU_SELECT_WIDTH'(ALU_ADD);
                            alu_src_b = 1'b1;
                        end
                        CLS_BRANCH: begin
                            alu_op      = ALU_SELECT_WIDTH'(ALU_SUB);
                            branch_cond = cond_q;
                            if (zero) begin
                                pc_write = 1'b1;
                                pc_src   = PC_SRC_BRANCH;
                            end
                        end
                        CLS_JUMP: begin
                            pc_write = 1'b1;
                            pc_src   = PC_SRC_JUMP;
                        end
                        default: ;
                    endcase
                end
                ST_MEM: begin
                    alu_op = ALU_SELECT_WIDTH'(ALU_ADD);
                    iord   = 1'b1;
                    if (class_q == CLS_LOAD) mem_read  = 1'b1;
                    else                     mem_write = 1'b1;
                end
                ST_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (class_q == CLS_LOAD);
                    alu_op     = (class_q == CLS_LOAD) ? ALU_SELECT_WIDTH'(ALU_ADD)
                                                       : ALU_SELECT_WIDTH'(alu_q);
                end
                ST_HALT: halted = 1'b1;
                ST_TRAP: trap   = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: vector table, directed corner sequences and
// randomized instruction streams against an instruction-level phase-sequence model.
module tb_cpu_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  alu_op;
    logic [1:0]  branch_cond;
    logic        alu_src_b;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        ir_write;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        reg_write;
    logic        mem_to_reg;
    logic        halted;
    logic        trap;
    logic [31:0] retired;

    cpu_control_fsm #(
        .DATA_WIDTH       (32),
        .ALU_SELECT_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .alu_op      (alu_op),
        .branch_cond (branch_cond),
        .alu_src_b   (alu_src_b),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .ir_write    (ir_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .iord        (iord),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .halted      (halted),
        .trap        (trap),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: each instruction is a string of phases, F=fetch D=decode X=exec M=mem
    // W=writeback H=halted T=trapped. F and M advance only on mem_ready.
    string       m_seq = "FD";
    int          m_pos = 0;
    int unsigned m_ret = 0;
    logic [31:0] m_instr = '0;
    bit          ret_known = 0;

    // Output bit layout used for model comparisons
    // [17]pc_write [16]ir_write [15]mem_read [14]mem_write [13]iord [12]reg_write
    // [11]mem_to_reg [10]halted [9]trap [8:7]pc_src [6]alu_src_b [5:2]alu_op [1:0]branch_cond
    localparam logic [17:0] MSK_STRB = 18'h3FF80;
    localparam logic [17:0] MSK_SRC  = 18'h00040;
    localparam logic [17:0] MSK_ALU  = 18'h0003C;
    localparam logic [17:0] MSK_BC   = 18'h00003;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
        end
    endtask

    function automatic string tail(input logic [31:0] w);
        int op = int'(w[31:28]);
        int a  = int'(w[27:24]);
        if (op == 15) return "H";
        if (op > 5 || (op <= 1 && a >= 8)) return "T";
        case (op)
            0, 1:    return "XW";
            2:       return "XMW";
            3:       return "XM";
            default: return "X";
        endcase
    endfunction

    function automatic void model_outs(input byte ph, input logic [31:0] li, input logic r,
                                       input logic mr, input logic z,
                                       output logic [17:0] e, output logic [17:0] m);
        int         op = int'(li[31:28]);
        logic [3:0] a  = li[27:24];
        logic pw = 0, irw = 0, mrd = 0, mw = 0, io = 0, rw = 0, m2r = 0, h = 0, t = 0, sb = 0;
        logic [1:0] pcs = 0, bc = 0;
        logic [3:0] al = 0;
        m = MSK_STRB;
        if (!r) begin
            m = '1;
        end else begin
            case (ph)
                "F": begin
                    mrd = 1;
                    if (mr) begin pw = 1; irw = 1; end
                end
                "X": begin
                    if (op <= 1) begin
                        al = a; sb = (op == 1); m |= MSK_ALU | MSK_SRC;
                    end else if (op <= 3) begin
                        al = 4'd2; sb = 1; m |= MSK_ALU | MSK_SRC;
                    end else if (op == 4) begin
                        al = 4'd3; bc = li[25:24]; m |= MSK_ALU | MSK_BC;
                        if (z) begin pw = 1; pcs = 2'd1; end
                    end else begin
                        pw = 1; pcs = 2'd2;
                    end
                end
                "M": begin
                    al = 4'd2; io = 1; m |= MSK_ALU;
                    if (op == 2) mrd = 1; else mw = 1;
                end
                "W": begin
                    rw = 1; m2r = (op == 2); al = (op == 2) ? 4'd2 : a; m |= MSK_ALU;
                end
                "H": h = 1;
                "T": t = 1;
                default: ;
            endcase
        end
        e = {pw, irw, mrd, mw, io, rw, m2r, h, t, pcs, sb, al, bc};
    endfunction

    // Drive one cycle's inputs and compare against the model mid-cycle
    task automatic apply(input logic r, input logic [31:0] ins, input logic mr, input logic z);
        logic [17:0] e, m, act;
        rst_n = r; instr = ins; mem_ready = mr; zero = z;
        #4;
        model_outs(m_seq[m_pos], m_instr, r, mr, z, e, m);
        act = {pc_write, ir_write, mem_read, mem_write, iord, reg_write, mem_to_reg,
               halted, trap, pc_src, alu_src_b, alu_op, branch_cond};
        chk("model_outs", 32'(act & m), 32'(e & m));
        if (ret_known) chk("model_retired", retired, m_ret);
    endtask

    // Cross the clock edge and advance the model with the inputs just applied
    task automatic tick();
        byte ph = m_seq[m_pos];
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_seq = "FD"; m_pos = 0; m_ret = 0; ret_known = 1;
            return;
        end
        case (ph)
            "F", "M": if (mem_ready) m_pos++;
            "D": begin
                m_instr = instr;
                m_seq   = {"FD", tail(instr)};
                m_pos++;
            end
            "X", "W": m_pos++;
            default: ;
        endcase
        if (m_pos >= m_seq.len()) begin
            m_ret++; m_seq = "FD"; m_pos = 0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int k = $urandom_range(99);
        logic [31:0] w = $urandom;
        if (k < 4) begin
            w[31:28] = 4'hF;
        end else if (k < 8) begin
            if (k[0]) w[31:28] = 4'($urandom_range(14, 6));
            else begin w[31:28] = 4'($urandom_range(1)); w[27] = 1'b1; end
        end else begin
            w[31:28] = 4'($urandom_range(5));
            if (w[31:28] <= 4'd1) w[27] = 1'b0;
        end
        return w;
    endfunction

    typedef struct {
        logic        r;
        logic [31:0] ins;
        logic        mr;
        logic        z;
        logic [8:0]  strb;      // pw irw mrd mw iord rw m2r halted trap
        logic [1:0]  pcs;
        logic [3:0]  alu;
        logic        alu_care;
        logic [1:0]  bc;
        logic        bc_care;
        logic [31:0] ret;
    } vec_t;

    vec_t tv[12];

    initial begin
        tv[0]  = '{1'b0, 32'h02000000, 1'b1, 1'b0, 9'b000000000, 2'd0, 4'd0, 1'b1, 2'd0, 1'b1, 32'd0};
        tv[1]  = '{1'b1, 32'h02000000, 1'b1, 1'b0, 9'b111000000, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 32'd0};
        tv[2]  = '{1'b1, 32'h02000000, 1'b1, 1'b0, 9'b000000000, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 32'd0};
        tv[3]  = '{1'b1, 32'h02000000, 1'b1, 1'b0, 9'b000000000, 2'd0, 4'd2, 1'b1, 2'd0, 1'b0, 32'd0};
        tv[4]  = '{1'b1, 32'h02000000, 1'b1, 1'b0, 9'b000001000, 2'd0, 4'd2, 1'b1, 2'd0, 1'b0, 32'd0};
        tv[5]  = '{1'b1, 32'h41000000, 1'b1, 1'b1, 9'b111000000, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 32'd1};
        tv[6]  = '{1'b1, 32'h41000000, 1'b1, 1'b1, 9'b000000000, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 32'd1};
        tv[7]  = '{1'b1, 32'h41000000, 1'b1, 1'b1, 9'b100000000, 2'd1, 4'd3, 1'b1, 2'd1, 1'b1, 32'd1};
        tv[8]  = '{1'b1, 32'h41000000, 1'b1, 1'b0, 9'b111000000, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 32'd2};
        tv[9]  = '{1'b1, 32'h41000000, 1'b1, 1'b0, 9'b000000000, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 32'd2};
        tv[10] = '{1'b1, 32'h41000000, 1'b1, 1'b0, 9'b000000000, 2'd0, 4'd3, 1'b1, 2'd1, 1'b1, 32'd2};
        tv[11] = '{1'b1, 32'h41000000, 1'b0, 1'b0, 9'b001000000, 2'd0, 4'd0, 1'b0, 2'd0, 1'b0, 32'd3};

        // Initial reset
        apply(1'b0, 32'h02000000, 1'b0, 1'b0); tick();
        apply(1'b0, 32'h02000000, 1'b1, 1'b0); tick();

        // Vector table: reset, RTYPE add, BRANCH NE taken then not taken
        for (int i = 0; i < 12; i++) begin
            apply(tv[i].r, tv[i].ins, tv[i].mr, tv[i].z);
            chk($sformatf("tv%0d_strb", i),
                {23'd0, pc_write, ir_write, mem_read, mem_write, iord, reg_write,
                 mem_to_reg, halted, trap}, {23'd0, tv[i].strb});
            chk($sformatf("tv%0d_pcsrc", i), {30'd0, pc_src}, {30'd0, tv[i].pcs});
            if (tv[i].alu_care) chk($sformatf("tv%0d_alu", i), {28'd0, alu_op}, {28'd0, tv[i].alu});
            if (tv[i].bc_care)  chk($sformatf("tv%0d_bc", i), {30'd0, branch_cond}, {30'd0, tv[i].bc});
            chk($sformatf("tv%0d_ret", i), retired, tv[i].ret);
            tick();
        end

        // LOAD with three wait cycles in MEM
        apply(1'b1, 32'h20000000, 1'b1, 1'b0); tick();
        apply(1'b1, 32'h20000000, 1'b1, 1'b0); tick();
        apply(1'b1, 32'h20000000, 1'b1, 1'b0);
        chk("ld_exec_alu", {28'd0, alu_op}, 32'd2);
        chk("ld_exec_srcb", {31'd0, alu_src_b}, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 32'h20000000, (i == 3), 1'b0);
            chk("ld_mem_read", {31'd0, mem_read}, 32'd1);
            chk("ld_mem_iord", {31'd0, iord}, 32'd1);
            tick();
        end
        apply(1'b1, 32'h20000000, 1'b0, 1'b0);
        chk("ld_wb_m2r", {31'd0, mem_to_reg}, 32'd1);
        chk("ld_wb_rw", {31'd0, reg_write}, 32'd1);
        tick();
        apply(1'b1, 32'h20000000, 1'b0, 1'b0);
        chk("ld_refetch_iord", {31'd0, iord}, 32'd0);
        chk("ld_ret", retired, 32'd4);
        tick();

        // Illegal opcode 7 traps; retired unchanged
        apply(1'b1, 32'h70000000, 1'b1, 1'b0); tick();
        apply(1'b1, 32'h70000000, 1'b1, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h70000000, 1'b1, 1'b1);
            chk("trap_op7", {31'd0, trap}, 32'd1);
            chk("trap_op7_ret", retired, 32'd4);
            tick();
        end
        apply(1'b0, 32'h0A000000, 1'b0, 1'b0); tick();

        // RTYPE with ALU field 0xA traps
        apply(1'b1, 32'h0A000000, 1'b1, 1'b0); tick();
        apply(1'b1, 32'h0A000000, 1'b1, 1'b0); tick();
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 32'h0A000000, 1'b1, 1'b0);
            chk("trap_alu_a", {31'd0, trap}, 32'd1);
            tick();
        end
        apply(1'b0, 32'hF0000000, 1'b0, 1'b0); tick();

        // HALT: halted and silent for 20 cycles
        apply(1'b1, 32'hF0000000, 1'b1, 1'b0); tick();
        apply(1'b1, 32'hF0000000, 1'b1, 1'b0); tick();
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 32'hF0000000, 1'(i), 1'b1);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_strobes", {26'd0, pc_write, ir_write, mem_read, mem_write, reg_write, trap}, 32'd0);
            tick();
        end
        apply(1'b0, 32'h02000000, 1'b0, 1'b0); tick();

        // One RTYPE to make retired nonzero, then reset in the middle of a STORE's MEM
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 32'h02000000, 1'b1, 1'b0); tick();
        end
        apply(1'b1, 32'h30000000, 1'b1, 1'b0); tick();
        apply(1'b1, 32'h30000000, 1'b1, 1'b0); tick();
        apply(1'b1, 32'h30000000, 1'b1, 1'b0); tick();
        apply(1'b1, 32'h30000000, 1'b0, 1'b0);
        chk("st_mem_write", {31'd0, mem_write}, 32'd1);
        chk("st_pre_ret", retired, 32'd1);
        tick();
        apply(1'b1, 32'h30000000, 1'b0, 1'b0); tick();
        apply(1'b0, 32'h30000000, 1'b1, 1'b0);
        chk("st_rst_mw", {31'd0, mem_write}, 32'd0);
        tick();
        apply(1'b1, 32'h02000000, 1'b0, 1'b0);
        chk("st_after_rst_mw", {31'd0, mem_write}, 32'd0);
        chk("st_after_rst_fetch", {30'd0, mem_read, iord}, 32'd2);
        chk("st_after_rst_ret", retired, 32'd0);
        tick();

        // Randomized instruction stream with random handshakes, flags and resets
        begin
            int          stuck = 0;
            logic [31:0] cur = 32'h02000000;
            for (int n = 0; n < 3000; n++) begin
                logic r;
                byte  ph = m_seq[m_pos];
                r = !(($urandom_range(99) == 0) || stuck > 6);
                if (ph == "F") cur = rand_instr();
                apply(r, cur, 1'($urandom_range(2) != 0), 1'($urandom_range(1)));
                tick();
                ph = m_seq[m_pos];
                stuck = (ph == "H" || ph == "T") ? stuck + 1 : 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
